// File: rtl/i2c_mmio_ctrl.sv
// i2c_mmio_ctrl: MMIO command front end that drives the i2c_master enable/busy handshake
module i2c_mmio_ctrl #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [15:0] DIV_RESET      = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_mmio_addr,
  input  logic [31:0] i_mmio_wdata,
  input  logic        i_mmio_we,
  output logic [31:0] o_mmio_rdata,
  output logic        o_enable,
  output logic        o_rw,
  output logic [7:0]  o_mosi_data,
  output logic [7:0]  o_reg_addr,
  output logic [6:0]  o_device_addr,
  output logic [15:0] o_divider,
  input  logic [7:0]  i_miso_data,
  input  logic        i_busy,
  output logic        o_irq
);
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_FREE, S_LAUNCH, S_WAIT_DONE} state_t;
  state_t        state_q;
  logic          irq_en_q, rw_q, active_q, done_q, err_q, ovr_q;
  logic          enable_q, rw_out_q;
  logic [6:0]    dev_q, dev_out_q;
  logic [7:0]    reg_q, reg_out_q, tx_q, tx_out_q, rx_q;
  logic [15:0]   div_q, div_out_q;
  logic [CW-1:0] ctr_q;
  logic          wr_ctrl, go, clr, unused_wdata;
  assign wr_ctrl       = i_mmio_we && i_mmio_addr == 3'd0;
  assign go            = wr_ctrl && i_mmio_wdata[0];
  assign clr           = wr_ctrl && i_mmio_wdata[3];
  assign unused_wdata  = ^i_mmio_wdata[31:16];
  assign o_enable      = enable_q;
  assign o_rw          = rw_out_q;
  assign o_mosi_data   = tx_out_q;
  assign o_reg_addr    = reg_out_q;
  assign o_device_addr = dev_out_q;
  assign o_divider     = div_out_q;
  assign o_irq         = done_q & irq_en_q;
  always_comb begin
    o_mmio_rdata = '0;
    case (i_mmio_addr)
      3'd0: o_mmio_rdata[2:1] = {irq_en_q, rw_q};
      3'd1: o_mmio_rdata[3:0] = {ovr_q, err_q, done_q, active_q};
      3'd2: o_mmio_rdata[6:0] = dev_q;
      3'd3: o_mmio_rdata[7:0] = reg_q;
      3'd4: o_mmio_rdata[7:0] = tx_q;
      3'd5: o_mmio_rdata[7:0] = rx_q;
      3'd6: o_mmio_rdata[15:0] = div_q;
      default: ;
    endcase
  end
  // Later assignments win: CLR, then overrun, then FSM completion/launch.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      irq_en_q  <= 1'b0;
      rw_q      <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
      enable_q  <= 1'b0;
      rw_out_q  <= 1'b0;
      dev_q     <= '0;
      dev_out_q <= '0;
      reg_q     <= '0;
      reg_out_q <= '0;
      tx_q      <= '0;
      tx_out_q  <= '0;
      rx_q      <= '0;
      div_q     <= DIV_RESET;
      div_out_q <= DIV_RESET;
      ctr_q     <= '0;
    end else begin
      if (i_mmio_we)
        case (i_mmio_addr)
          3'd0: {irq_en_q, rw_q} <= i_mmio_wdata[2:1];
          3'd2: dev_q <= i_mmio_wdata[6:0];
          3'd3: reg_q <= i_mmio_wdata[7:0];
          3'd4: tx_q <= i_mmio_wdata[7:0];
          3'd6: div_q <= i_mmio_wdata[15:0];
          default: ;
        endcase
      if (clr) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        ovr_q  <= 1'b0;
      end
      if (go && active_q) ovr_q <= 1'b1;
      case (state_q)
        S_IDLE:
          if (go) begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            active_q  <= 1'b1;
            dev_out_q <= dev_q;
            reg_out_q <= reg_q;
            tx_out_q  <= tx_q;
            div_out_q <= div_q;
            rw_out_q  <= i_mmio_wdata[1];
            state_q   <= S_WAIT_FREE;
          end
        S_WAIT_FREE:
          if (!i_busy) begin
            enable_q <= 1'b1;
            ctr_q    <= '0;
            state_q  <= S_LAUNCH;
          end
        S_LAUNCH:
          if (i_busy) begin
            enable_q <= 1'b0;
            state_q  <= S_WAIT_DONE;
          end else if (ctr_q == CW'(TIMEOUT_CYCLES - 1)) begin
            enable_q <= 1'b0;
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            active_q <= 1'b0;
            state_q  <= S_IDLE;
          end else ctr_q <= ctr_q + 1'b1;
        S_WAIT_DONE:
          if (!i_busy) begin
            if (rw_out_q) rx_q <= i_miso_data;
            done_q   <= 1'b1;
            active_q <= 1'b0;
            state_q  <= S_IDLE;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_mmio_ctrl.sv
// tb_i2c_mmio_ctrl: randomized transactions against a register-level model with a behavioural i2c_master stand-in
module tb_i2c_mmio_ctrl;
  logic        clk = 0, rst_n = 0, we = 0, busy = 0;
  logic [2:0]  addr = 0;
  logic [31:0] wdata = 0, rdata;
  logic [7:0]  miso = 0, last_miso = 0, mosi, rega;
  logic [6:0]  deva;
  logic [15:0] div;
  logic        en, rw, irq;
  int          checks = 0, failures = 0, n_txn = 0;
  bit          slave_on = 1;
  logic [6:0]  m_dev, s_dev;
  logic [7:0]  m_reg, m_tx, m_rx, s_reg, s_tx;
  logic [15:0] m_div, s_div;
  logic        m_rw, m_irqen, m_done, m_err, m_ovr, m_act, s_rw;
  i2c_mmio_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mmio_addr(addr), .i_mmio_wdata(wdata), .i_mmio_we(we),
    .o_mmio_rdata(rdata), .o_enable(en), .o_rw(rw), .o_mosi_data(mosi), .o_reg_addr(rega),
    .o_device_addr(deva), .o_divider(div), .i_miso_data(miso), .i_busy(busy), .o_irq(irq)
  );
  always #10 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Stand-in i2c_master: answers o_enable with one busy pulse, then presents random read data.
  initial forever begin
    @(negedge clk);
    if (slave_on && en && !busy) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      busy = 1;
      n_txn++;
      @(negedge clk);
      check("en_drop", 32'(en), 0);
      repeat ($urandom_range(5, 11)) @(negedge clk);
      miso = 8'($urandom);
      last_miso = miso;
      busy = 0;
    end
  end
  task automatic model_reset();
    {m_dev, m_reg, m_tx, m_rx, s_dev, s_reg, s_tx} = '0;
    {m_rw, m_irqen, m_done, m_err, m_ovr, m_act, s_rw} = '0;
    m_div = 16'hFFFF;
    s_div = 16'hFFFF;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; we = 1;
    @(negedge clk);
    we = 0;
    case (a)
      3'd0: begin
        m_rw = d[1];
        m_irqen = d[2];
        if (d[3]) {m_done, m_err, m_ovr} = '0;
        if (d[0]) begin
          if (m_act) m_ovr = 1;
          else begin
            {m_done, m_err} = '0;
            m_act = 1;
            s_dev = m_dev; s_reg = m_reg; s_tx = m_tx; s_div = m_div; s_rw = m_rw;
          end
        end
      end
      3'd2: m_dev = d[6:0];
      3'd3: m_reg = d[7:0];
      3'd4: m_tx = d[7:0];
      3'd6: m_div = d[15:0];
      default: ;
    endcase
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    addr = a;
    #1 d = rdata;
  endtask
  task automatic check_regs();
    logic [31:0] v;
    rd(3'd0, v); check("ctrl", v, {29'b0, m_irqen, m_rw, 1'b0});
    rd(3'd1, v); check("status", v, {28'b0, m_ovr, m_err, m_done, m_act});
    rd(3'd2, v); check("dev_addr", v, {25'b0, m_dev});
    rd(3'd3, v); check("reg_addr", v, {24'b0, m_reg});
    rd(3'd4, v); check("tx_data", v, {24'b0, m_tx});
    rd(3'd5, v); check("rx_data", v, {24'b0, m_rx});
    rd(3'd6, v); check("divider", v, {16'b0, m_div});
    rd(3'd7, v); check("reg7", v, 0);
    check("irq", 32'(irq), 32'(m_done & m_irqen));
  endtask
  task automatic check_shadow();
    check("o_device_addr", 32'(deva), 32'(s_dev));
    check("o_reg_addr", 32'(rega), 32'(s_reg));
    check("o_mosi_data", 32'(mosi), 32'(s_tx));
    check("o_divider", 32'(div), 32'(s_div));
    check("o_rw", 32'(rw), 32'(s_rw));
  endtask
  task automatic wait_idle();
    logic [31:0] v;
    int n = 0;
    do begin
      @(negedge clk);
      rd(3'd1, v);
      n++;
    end while (v[0] && n < 300);
    check("idle_wait", 32'(v[0]), 0);
    m_act = 0;
    m_done = 1;
    if (s_rw) m_rx = last_miso;
  endtask
  initial begin : main
    logic [31:0] r, v;
    int b, n;
    model_reset();
    repeat (3) @(negedge clk);
    check_regs();
    check_shadow();
    check("reset_en", 32'(en), 0);
    rst_n = 1;
    wr(3'd2, 32'h11); wr(3'd3, 32'h00); wr(3'd4, 32'hDC);
    b = n_txn;
    wr(3'd0, 32'h1);
    rd(3'd1, v); check("go_status", v, 32'h1);
    check("go_en_lat1", 32'(en), 0);
    @(negedge clk);
    check("go_en_lat2", 32'(en), 1);
    wr(3'd4, 32'h55);
    check_shadow();
    rd(3'd4, v); check("tx_during_active", v, 32'h55);
    wait_idle();
    check_regs();
    check_shadow();
    check("txn_count", n_txn - b, 1);
    wr(3'd0, 32'h7);
    wait_idle();
    check_regs();
    wr(3'd0, 32'hC);
    check_regs();
    slave_on = 0;
    b = n_txn;
    r = {24'b0, m_rx};
    wr(3'd0, 32'h3);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (en) n++;
      else if (n > 0) break;
    end
    check("timeout_len", n, 16);
    m_act = 0; m_done = 1; m_err = 1;
    check_regs();
    rd(3'd5, v); check("rx_kept_on_timeout", v, r);
    check("timeout_txn", n_txn - b, 0);
    slave_on = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 4)) wr(3'($urandom_range(1, 7)), $urandom);
      b = n_txn;
      r = $urandom;
      wr(3'd0, {r[31:1], 1'b1});
      check_shadow();
      rd(3'd1, v); check("active", 32'(v[0]), 1);
      repeat ($urandom_range(0, 3)) begin
        case ($urandom_range(0, 2))
          0: wr(3'd4, $urandom);
          1: wr(3'd2, $urandom);
          default: wr(3'd0, $urandom | 32'h1);
        endcase
      end
      check_shadow();
      wait_idle();
      check_regs();
      check_shadow();
      check("txn_count", n_txn - b, 1);
      if ($urandom_range(0, 1)) begin
        wr(3'd0, ($urandom & 32'h6) | 32'h8);
        check_regs();
      end
    end
    wr(3'd0, 32'h1);
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_seen", 32'(busy), 1);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    model_reset();
    check("rst_en", 32'(en), 0);
    check_regs();
    check_shadow();
    rst_n = 1;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_released", 32'(busy), 0);
    check_regs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
